execute_cycle: RTL and testbench

Execute (EX) stage of the 24-bit five-stage pipelined processor.
- Selects forwarded operands and computes the ALU result.
- Resolves branches: taken flag and target address.
- Registers the control and data signals into the EX/MEM pipeline register, which feeds the memory stage.

---
 rtl/execute_cycle.sv | 125 ++++++++++++
 tb/tb_execute_cycle.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/execute_cycle.sv
// Execute stage of the 24-bit five-stage pipeline.
// Picks forwarded operands, runs the ALU, resolves conditional branches
// and registers the results into the EX/MEM pipeline register.
module execute_cycle #(
    parameter int DATA_WIDTH     = 24,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RegWriteE,
    input  logic                      ALUSrcE,
    input  logic                      MemWriteE,
    input  logic                      ResultSrcE,
    input  logic                      BranchE,
    input  logic [2:0]                ALUControlE,
    input  logic [DATA_WIDTH-1:0]     RD1_E,
    input  logic [DATA_WIDTH-1:0]     RD2_E,
    input  logic [DATA_WIDTH-1:0]     Imm_Ext_E,
    input  logic [REG_ADDR_WIDTH-1:0] RD_E,
    input  logic [DATA_WIDTH-1:0]     PCE,
    input  logic [DATA_WIDTH-1:0]     PCPlus4E,
    input  logic [DATA_WIDTH-1:0]     ResultW,
    input  logic [1:0]                ForwardA_E,
    input  logic [1:0]                ForwardB_E,
    output logic                      PCSrcE,
    output logic [DATA_WIDTH-1:0]     PCTargetE,
    output logic                      RegWriteM,
    output logic                      MemWriteM,
    output logic                      ResultSrcM,
    output logic [REG_ADDR_WIDTH-1:0] RD_M,
    output logic [DATA_WIDTH-1:0]     PCPlus4M,
    output logic [DATA_WIDTH-1:0]     WriteDataM,
    output logic [DATA_WIDTH-1:0]     ALU_ResultM
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b_fwd;
    logic [DATA_WIDTH-1:0] src_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] mul_low;
    logic [DATA_WIDTH-1:0] div_quot;
    logic                  zero;

    // Operand A forwarding; encoding 11 is unused and falls back to the register value.
    always_comb begin
        src_a = RD1_E;
        case (ForwardA_E)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALU_ResultM;
            default: src_a = RD1_E;
        endcase
    end

    // Operand B forwarding; the forwarded value is also the store data.
    always_comb begin
        src_b_fwd = RD2_E;
        case (ForwardB_E)
            FWD_WB:  src_b_fwd = ResultW;
            FWD_MEM: src_b_fwd = ALU_ResultM;
            default: src_b_fwd = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : src_b_fwd;

    // Self-determined width keeps only the low DATA_WIDTH bits of the product.
    assign mul_low  = src_a * src_b;
    // Divide by zero saturates to all ones instead of being undefined.
    assign div_quot = (src_b == '0) ? {DATA_WIDTH{1'b1}} : (src_a / src_b);

    // Unsigned ALU, all results wrap modulo 2^DATA_WIDTH.
    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_MUL: alu_result = mul_low;
            ALU_DIV: alu_result = div_quot;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLT: alu_result = {{(DATA_WIDTH-1){1'b0}}, (src_a < src_b)};
            default: alu_result = '0;
        endcase
    end

    assign zero      = (alu_result == '0);
    assign PCSrcE    = BranchE & zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    // EX/MEM pipeline register; reset discards whatever was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= src_b_fwd;
            ALU_ResultM <= alu_result;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for the execute stage: hand-computed vectors, one after another.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [23:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [23:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [23:0] PCPlus4M, WriteDataM, ALU_ResultM;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM)
    );

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
        ALUControlE = 3'b000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
        PCE = 0; PCPlus4E = 0; ResultW = 0; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        RD1_E = 24'd10; RD2_E = 24'd5; RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1;
        RD_E = 5'd3; PCPlus4E = 24'd44;
        tick();
        check("rst_alu", ALU_ResultM, 24'd0);
        check("rst_wd", WriteDataM, 24'd0);
        check("rst_regwrite", {23'd0, RegWriteM}, 24'd0);
        check("rst_memwrite", {23'd0, MemWriteM}, 24'd0);
        check("rst_resultsrc", {23'd0, ResultSrcM}, 24'd0);
        check("rst_rd", {19'd0, RD_M}, 24'd0);
        check("rst_pcplus4", PCPlus4M, 24'd0);

        // add from registers
        rst = 1'b0;
        idle_inputs();
        RD1_E = 24'd10; RD2_E = 24'd5;
        #1 check("add_pcsrc", {23'd0, PCSrcE}, 24'd0);
        tick();
        check("add_alu", ALU_ResultM, 24'd15);
        check("add_wd", WriteDataM, 24'd5);
        check("add_regwrite", {23'd0, RegWriteM}, 24'd0);

        // add immediate, branch target
        ALUSrcE = 1; Imm_Ext_E = 24'd8; PCE = 24'd100;
        #1 check("imm_target", PCTargetE, 24'd108);
        tick();
        check("addi_alu", ALU_ResultM, 24'd18);
        check("addi_wd", WriteDataM, 24'd5);

        // subtract
        ALUSrcE = 0; ALUControlE = 3'b001; RD1_E = 24'd30; RD2_E = 24'd25;
        tick();
        check("sub_alu", ALU_ResultM, 24'd5);

        // subtract wrapping below zero
        RD1_E = 24'd3; RD2_E = 24'd5;
        tick();
        check("sub_wrap", ALU_ResultM, 24'hFFFFFE);

        // multiply, including truncation
        ALUControlE = 3'b010; RD1_E = 24'd4; RD2_E = 24'd3;
        tick();
        check("mul_alu", ALU_ResultM, 24'd12);
        RD1_E = 24'h001000; RD2_E = 24'h001001;
        tick();
        check("mul_trunc", ALU_ResultM, 24'h001000);

        // divide by zero then a normal divide
        ALUControlE = 3'b011; RD1_E = 24'd100; RD2_E = 24'd0;
        tick();
        check("div_zero", ALU_ResultM, 24'hFFFFFF);
        RD2_E = 24'd4;
        tick();
        check("div_alu", ALU_ResultM, 24'd25);

        // forwarding from ALU_ResultM (25) into B
        ALUControlE = 3'b000; ForwardB_E = 2'b10; RD1_E = 24'd100; RD2_E = 24'd999;
        tick();
        check("fwdb_mem_alu", ALU_ResultM, 24'd125);
        check("fwdb_mem_wd", WriteDataM, 24'd25);

        // A from writeback, B still from ALU_ResultM (125)
        ForwardA_E = 2'b01; ResultW = 24'd50;
        tick();
        check("fwda_wb_alu", ALU_ResultM, 24'd175);
        check("fwda_wb_wd", WriteDataM, 24'd125);

        // forward select 11 falls back to register values
        ForwardA_E = 2'b11; ForwardB_E = 2'b11; RD1_E = 24'd7; RD2_E = 24'd2;
        tick();
        check("fwd11_alu", ALU_ResultM, 24'd9);

        // B from writeback
        ForwardA_E = 2'b00; ForwardB_E = 2'b01; ResultW = 24'd40;
        tick();
        check("fwdb_wb_alu", ALU_ResultM, 24'd47);
        check("fwdb_wb_wd", WriteDataM, 24'd40);

        // add wraps to zero
        ForwardB_E = 2'b00; RD1_E = 24'hFFFFFF; RD2_E = 24'd1;
        tick();
        check("add_wrap", ALU_ResultM, 24'd0);

        // logic ops and set-less-than
        RD1_E = 24'hF0F0F0; RD2_E = 24'h0FF00F;
        ALUControlE = 3'b100; tick(); check("and_alu", ALU_ResultM, 24'h00F000);
        ALUControlE = 3'b101; tick(); check("or_alu", ALU_ResultM, 24'hFFF0FF);
        ALUControlE = 3'b110; tick(); check("xor_alu", ALU_ResultM, 24'hFF00FF);
        ALUControlE = 3'b111; tick(); check("slt_false", ALU_ResultM, 24'd0);
        RD1_E = 24'd3; RD2_E = 24'd4;
        tick(); check("slt_true", ALU_ResultM, 24'd1);

        // immediate must not leak into store data
        ALUControlE = 3'b000; ALUSrcE = 1; Imm_Ext_E = 24'd100; RD2_E = 24'd77;
        tick();
        check("imm_alu", ALU_ResultM, 24'd103);
        check("imm_wd", WriteDataM, 24'd77);

        // branch taken / not taken
        ALUSrcE = 0; ALUControlE = 3'b001; RD1_E = 24'd10; RD2_E = 24'd10;
        BranchE = 1; PCE = 24'd100; Imm_Ext_E = 24'd8;
        #1;
        check("br_taken", {23'd0, PCSrcE}, 24'd1);
        check("br_target", PCTargetE, 24'd108);
        RD2_E = 24'd9;
        #1 check("br_not_taken", {23'd0, PCSrcE}, 24'd0);
        RD2_E = 24'd10; BranchE = 0;
        #1 check("br_disabled", {23'd0, PCSrcE}, 24'd0);
        PCE = 24'hFFFFFC; Imm_Ext_E = 24'd8;
        #1 check("target_wrap", PCTargetE, 24'd4);
        tick();

        // control pass-through
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RD_E = 5'd7; PCPlus4E = 24'd104;
        tick();
        check("pt_regwrite", {23'd0, RegWriteM}, 24'd1);
        check("pt_memwrite", {23'd0, MemWriteM}, 24'd1);
        check("pt_resultsrc", {23'd0, ResultSrcM}, 24'd1);
        check("pt_rd", {19'd0, RD_M}, 24'd7);
        check("pt_pcplus4", PCPlus4M, 24'd104);

        // mid-stream reset; combinational outputs stay live
        rst = 1'b1; BranchE = 1; PCE = 24'd200; Imm_Ext_E = 24'd4;
        #1;
        check("rst_comb_target", PCTargetE, 24'd204);
        check("rst_comb_pcsrc", {23'd0, PCSrcE}, 24'd1);
        tick();
        check("mrst_regwrite", {23'd0, RegWriteM}, 24'd0);
        check("mrst_memwrite", {23'd0, MemWriteM}, 24'd0);
        check("mrst_resultsrc", {23'd0, ResultSrcM}, 24'd0);
        check("mrst_rd", {19'd0, RD_M}, 24'd0);
        check("mrst_pcplus4", PCPlus4M, 24'd0);
        check("mrst_wd", WriteDataM, 24'd0);
        check("mrst_alu", ALU_ResultM, 24'd0);

        // first edge after reset captures fresh inputs
        rst = 1'b0;
        idle_inputs();
        RD1_E = 24'd15; RD2_E = 24'd10;
        tick();
        check("post_rst_alu", ALU_ResultM, 24'd25);
        check("post_rst_wd", WriteDataM, 24'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
